// File: rtl/decoder_hs.sv
// rtl/decoder_hs.sv - decode stage with valid/ready handshake, register file, load-use interlock and bypass
module decoder_hs #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid_i,
    output logic             if_ready_o,
    input  logic [XLEN-1:0]  if_pc_i,
    input  logic [31:0]      if_instr_i,
    input  logic             flush_i,
    input  logic             wb_we_i,
    input  logic [AW-1:0]    wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             ex_ready_i,
    output logic             id_valid_o,
    output logic [XLEN-1:0]  id_pc_o,
    output logic [XLEN-1:0]  id_rs1_data_o,
    output logic [XLEN-1:0]  id_rs2_data_o,
    output logic [XLEN-1:0]  id_imm_o,
    output logic [4:0]       id_rs1_o,
    output logic [4:0]       id_rs2_o,
    output logic [4:0]       id_rd_o,
    output logic [2:0]       id_funct3_o,
    output logic [6:0]       id_opcode_o,
    output logic [4:0]       id_ctrl_o,
    output logic             id_illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [XLEN-1:0]  rf_q [NUM_REGS];
    logic             id_valid_q, id_illegal_q;
    logic [XLEN-1:0]  id_pc_q, id_rs1_data_q, id_rs2_data_q, id_imm_q;
    logic [4:0]       id_rs1_q, id_rs2_q, id_rd_q, id_ctrl_q;
    logic [2:0]       id_funct3_q;
    logic [6:0]       id_opcode_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [6:0]      opc;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic            known, rs1_used, rs2_used, bad_reg;
    logic [4:0]      ctrl_raw, ctrl_d;
    logic            illegal_d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d, rs1_data_d, rs2_data_d;
    logic            adv, hazard, accept;

    assign opc   = if_instr_i[6:0];
    assign rs1_f = if_instr_i[19:15];
    assign rs2_f = if_instr_i[24:20];
    assign rd_f  = if_instr_i[11:7];

    always_comb begin
        known    = 1'b1;
        ctrl_raw = 5'b00000;
        imm32    = 32'd0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                ctrl_raw = 5'b10000;
                imm32    = {if_instr_i[31:12], 12'd0};
                rs1_used = 1'b0;
            end
            OP_JAL: begin
                ctrl_raw = 5'b10001;
                imm32    = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                            if_instr_i[20], if_instr_i[30:21], 1'b0};
                rs1_used = 1'b0;
            end
            OP_JALR: begin
                ctrl_raw = 5'b10001;
                imm32    = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            end
            OP_OPIMM: begin
                ctrl_raw = 5'b10000;
                imm32    = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            end
            OP_LOAD: begin
                ctrl_raw = 5'b11000;
                imm32    = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            end
            OP_OP: begin
                ctrl_raw = 5'b10000;
                rs2_used = 1'b1;
            end
            OP_STORE: begin
                ctrl_raw = 5'b00100;
                imm32    = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
                rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_raw = 5'b00010;
                imm32    = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                            if_instr_i[30:25], if_instr_i[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // Only fields the instruction actually uses can make it illegal on RV32E
        bad_reg   = (rs1_used && 32'(rs1_f) >= NUM_REGS) ||
                    (rs2_used && 32'(rs2_f) >= NUM_REGS) ||
                    (ctrl_raw[4] && 32'(rd_f) >= NUM_REGS);
        illegal_d = !known || bad_reg;
        ctrl_d    = illegal_d ? 5'b00000 : ctrl_raw;
    end

    assign imm_d = XLEN'($signed(imm32));

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || 32'(idx) >= NUM_REGS) return '0;
        if (BYPASS != 0 && wb_we_i && 5'(wb_rd_i) == idx) return wb_data_i;
        return rf_q[idx[AW-1:0]];
    endfunction

    assign rs1_data_d = rf_read(rs1_f);
    assign rs2_data_d = rf_read(rs2_f);

    assign adv    = !id_valid_q || ex_ready_i;
    assign hazard = id_valid_q && id_ctrl_q[3] && id_rd_q != 5'd0 &&
                    ((rs1_used && rs1_f == id_rd_q) || (rs2_used && rs2_f == id_rd_q));
    assign if_ready_o = rst_n && (flush_i || (adv && !hazard));
    assign accept     = if_valid_i && if_ready_o && !flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            id_valid_q    <= 1'b0;
            id_illegal_q  <= 1'b0;
            id_pc_q       <= '0;
            id_rs1_data_q <= '0;
            id_rs2_data_q <= '0;
            id_imm_q      <= '0;
            id_rs1_q      <= '0;
            id_rs2_q      <= '0;
            id_rd_q       <= '0;
            id_ctrl_q     <= '0;
            id_funct3_q   <= '0;
            id_opcode_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (wb_we_i && wb_rd_i != '0) rf_q[wb_rd_i] <= wb_data_i;
            if (if_valid_i && !if_ready_o && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_i) begin
                id_valid_q <= 1'b0;
            end else if (adv) begin
                id_valid_q <= accept;
                if (accept) begin
                    id_pc_q       <= if_pc_i;
                    id_rs1_data_q <= rs1_data_d;
                    id_rs2_data_q <= rs2_data_d;
                    id_imm_q      <= imm_d;
                    id_rs1_q      <= rs1_f;
                    id_rs2_q      <= rs2_f;
                    id_rd_q       <= rd_f;
                    id_ctrl_q     <= ctrl_d;
                    id_funct3_q   <= if_instr_i[14:12];
                    id_opcode_q   <= opc;
                    id_illegal_q  <= illegal_d;
                end
            end else begin
                // Held operands follow write-back so execute never sees a stale value
                if (wb_we_i && id_rs1_q != 5'd0 && 5'(wb_rd_i) == id_rs1_q) id_rs1_data_q <= wb_data_i;
                if (wb_we_i && id_rs2_q != 5'd0 && 5'(wb_rd_i) == id_rs2_q) id_rs2_data_q <= wb_data_i;
            end
        end
    end

    assign id_valid_o    = id_valid_q;
    assign id_pc_o       = id_pc_q;
    assign id_rs1_data_o = id_rs1_data_q;
    assign id_rs2_data_o = id_rs2_data_q;
    assign id_imm_o      = id_imm_q;
    assign id_rs1_o      = id_rs1_q;
    assign id_rs2_o      = id_rs2_q;
    assign id_rd_o       = id_rd_q;
    assign id_funct3_o   = id_funct3_q;
    assign id_opcode_o   = id_opcode_q;
    assign id_ctrl_o     = id_ctrl_q;
    assign id_illegal_o  = id_illegal_q;
    assign stall_cnt_o   = stall_cnt_q;
endmodule
